// File: rtl/lmc1992_mixer.sv
// LMC1992-style volume/tone controller: microwire command decoder plus a
// two-stage DMA/PSG mixing and attenuation pipeline.
module lmc1992_mixer (
    input  logic       clk,
    input  logic       reset,
    input  logic       mw_strobe,
    input  logic       mw_clk,
    input  logic       mw_data,
    input  logic       mw_done,
    input  logic [7:0] dma_l,
    input  logic [7:0] dma_r,
    input  logic [7:0] psg,
    output logic [9:0] audio_l,
    output logic [9:0] audio_r,
    output logic [3:0] bass,
    output logic [3:0] treble,
    output logic       cmd_ok
);

    logic [10:0]       shift_q, shift_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [5:0]        master_q, master_d;
    logic [4:0]        left_q, left_d;
    logic [4:0]        right_q, right_d;
    logic [3:0]        bass_q, bass_d;
    logic [3:0]        treble_q, treble_d;
    logic [1:0]        mix_q, mix_d;
    logic              cmd_ok_q, cmd_ok_d;
    logic signed [9:0] sum_l_q, sum_l_d, sum_r_q, sum_r_d;
    logic [7:0]        gain_l_q, gain_l_d, gain_r_q, gain_r_d;
    logic [9:0]        audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic [5:0]        cmd_val;

    // gain[i] = round(255 * 10^(-i/10)), i in 2 dB steps
    function automatic logic [7:0] gain_rom(input logic [6:0] idx);
        case (idx)
            7'd0:  return 8'd255;
            7'd1:  return 8'd203;
            7'd2:  return 8'd161;
            7'd3:  return 8'd128;
            7'd4:  return 8'd102;
            7'd5:  return 8'd81;
            7'd6:  return 8'd64;
            7'd7:  return 8'd51;
            7'd8:  return 8'd40;
            7'd9:  return 8'd32;
            7'd10: return 8'd26;
            7'd11: return 8'd20;
            7'd12: return 8'd16;
            7'd13: return 8'd13;
            7'd14: return 8'd10;
            7'd15: return 8'd8;
            7'd16: return 8'd6;
            7'd17: return 8'd5;
            7'd18: return 8'd4;
            7'd19: return 8'd3;
            7'd20: return 8'd3;
            7'd21: return 8'd2;
            7'd22: return 8'd2;
            7'd23, 7'd24, 7'd25, 7'd26, 7'd27: return 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] chan_gain(input logic [5:0] master, input logic [4:0] chan);
        logic [6:0] idx;
        idx = (7'd40 - {1'b0, master}) + (7'd20 - {2'b00, chan});
        if (idx > 7'd40) idx = 7'd40;
        return gain_rom(idx);
    endfunction

    // Flipping the MSB turns offset binary into two's complement (x - 128)
    function automatic logic signed [9:0] mix_sum(input logic [7:0] dma, input logic [7:0] p8,
                                                  input logic [1:0] mode);
        logic signed [9:0] d;
        logic signed [9:0] p;
        d = $signed({{2{~dma[7]}}, ~dma[7], dma[6:0]});
        p = $signed({{2{~p8[7]}}, ~p8[7], p8[6:0]});
        case (mode)
            2'b00:   return d + (p >>> 2);
            2'b01:   return d + p;
            default: return d;
        endcase
    endfunction

    function automatic logic [9:0] scale(input logic signed [9:0] s, input logic [7:0] g);
        logic signed [18:0] prod;
        prod = s * $signed({1'b0, g});
        return 10'(prod >>> 8);
    endfunction

    // A strobe coinciding with mw_done is shifted first, so the word is judged on the _d values
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        master_d = master_q;
        left_d   = left_q;
        right_d  = right_q;
        bass_d   = bass_q;
        treble_d = treble_q;
        mix_d    = mix_q;
        cmd_ok_d = 1'b0;
        cmd_val  = 6'd0;
        if (mw_strobe && mw_clk) begin
            shift_d = {shift_q[9:0], mw_data};
            if (cnt_q != 4'd12) cnt_d = cnt_q + 4'd1;
        end
        if (mw_done) begin
            if (cnt_d == 4'd11 && shift_d[10:9] == 2'b10) begin
                cmd_val = shift_d[5:0];
                case (shift_d[8:6])
                    3'b000: begin mix_d = cmd_val[1:0]; cmd_ok_d = 1'b1; end
                    3'b001: begin bass_d = (cmd_val > 6'd12) ? 4'd12 : cmd_val[3:0]; cmd_ok_d = 1'b1; end
                    3'b010: begin treble_d = (cmd_val > 6'd12) ? 4'd12 : cmd_val[3:0]; cmd_ok_d = 1'b1; end
                    3'b011: begin master_d = (cmd_val > 6'd40) ? 6'd40 : cmd_val; cmd_ok_d = 1'b1; end
                    3'b100: begin right_d = (cmd_val > 6'd20) ? 5'd20 : cmd_val[4:0]; cmd_ok_d = 1'b1; end
                    3'b101: begin left_d = (cmd_val > 6'd20) ? 5'd20 : cmd_val[4:0]; cmd_ok_d = 1'b1; end
                    default: ;
                endcase
            end
            cnt_d = 4'd0;
        end
    end

    always_comb begin
        sum_l_d   = mix_sum(dma_l, psg, mix_q);
        sum_r_d   = mix_sum(dma_r, psg, mix_q);
        gain_l_d  = chan_gain(master_q, left_q);
        gain_r_d  = chan_gain(master_q, right_q);
        audio_l_d = scale(sum_l_q, gain_l_q);
        audio_r_d = scale(sum_r_q, gain_r_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= 11'd0;
            cnt_q     <= 4'd0;
            master_q  <= 6'd40;
            left_q    <= 5'd20;
            right_q   <= 5'd20;
            bass_q    <= 4'd6;
            treble_q  <= 4'd6;
            mix_q     <= 2'b01;
            cmd_ok_q  <= 1'b0;
            sum_l_q   <= 10'sd0;
            sum_r_q   <= 10'sd0;
            gain_l_q  <= 8'd0;
            gain_r_q  <= 8'd0;
            audio_l_q <= 10'd0;
            audio_r_q <= 10'd0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            master_q  <= master_d;
            left_q    <= left_d;
            right_q   <= right_d;
            bass_q    <= bass_d;
            treble_q  <= treble_d;
            mix_q     <= mix_d;
            cmd_ok_q  <= cmd_ok_d;
            sum_l_q   <= sum_l_d;
            sum_r_q   <= sum_r_d;
            gain_l_q  <= gain_l_d;
            gain_r_q  <= gain_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
        end
    end

    assign audio_l = audio_l_q;
    assign audio_r = audio_r_q;
    assign bass    = bass_q;
    assign treble  = treble_q;
    assign cmd_ok  = cmd_ok_q;

endmodule

// File: tb/tb_lmc1992_mixer.sv
// Self-checking bench for lmc1992_mixer: table-driven microwire frames,
// randomized audio against a gain-formula model, and reset corner cases.
module tb_lmc1992_mixer;

    logic       clk = 1'b0;
    logic       reset, mw_strobe, mw_clk, mw_data, mw_done;
    logic [7:0] dma_l, dma_r, psg;
    logic [9:0] audio_l, audio_r;
    logic [3:0] bass, treble;
    logic       cmd_ok;

    int tests = 0;
    int fails = 0;

    int mMaster, mLeft, mRight, mBass, mTreble, mMix;

    typedef struct {
        logic [11:0] bits;
        int          n;
        bit          doneWithLast;
        bit          expOk;
        int          expBass;
        int          expTreble;
    } vec_t;

    vec_t vecs[12];

    lmc1992_mixer dut (
        .clk(clk), .reset(reset), .mw_strobe(mw_strobe), .mw_clk(mw_clk),
        .mw_data(mw_data), .mw_done(mw_done), .dma_l(dma_l), .dma_r(dma_r),
        .psg(psg), .audio_l(audio_l), .audio_r(audio_r), .bass(bass),
        .treble(treble), .cmd_ok(cmd_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int gainOf(int idx);
        real g;
        g = 255.0 * $pow(10.0, -idx / 10.0);
        return int'($floor(g + 0.5 + 1.0e-9));
    endfunction

    function automatic int expAudio(int dma, int p, int ch);
        int sd, sp, sum, idx;
        sd = dma - 128;
        sp = p - 128;
        case (mMix)
            0:       sum = sd + int'($floor(sp / 4.0));
            1:       sum = sd + sp;
            default: sum = sd;
        endcase
        idx = (40 - mMaster) + (20 - ch);
        if (idx > 40) idx = 40;
        return int'($floor(real'(sum * gainOf(idx)) / 256.0));
    endfunction

    function automatic int minOf(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit modelFrame(logic [11:0] bits, int n);
        int cmd, val;
        if (n != 11 || bits[10:9] != 2'b10) return 1'b0;
        cmd = int'(bits[8:6]);
        val = int'(bits[5:0]);
        case (cmd)
            0: mMix    = val % 4;
            1: mBass   = minOf(val, 12);
            2: mTreble = minOf(val, 12);
            3: mMaster = minOf(val, 40);
            4: mRight  = minOf(val, 20);
            5: mLeft   = minOf(val, 20);
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [11:0] bits, input int n, input bit doneWithLast);
        for (int i = n - 1; i >= 0; i--) begin
            if ($urandom_range(0, 3) == 0) begin
                mw_strobe = 1'b1; mw_clk = 1'b0; mw_data = 1'($urandom_range(0, 1));
                tick(1);
                mw_strobe = 1'b0;
                tick(7);
            end
            mw_strobe = 1'b1; mw_clk = 1'b1; mw_data = bits[i];
            mw_done = doneWithLast && (i == 0);
            tick(1);
            mw_strobe = 1'b0; mw_clk = 1'b0; mw_done = 1'b0;
            if (!(doneWithLast && i == 0)) tick(7);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [11:0] bits, input int n,
                                 input bit doneWithLast, input bit expOk);
        sendBits(bits, n, doneWithLast && n > 0);
        if (!(doneWithLast && n > 0)) begin
            mw_done = 1'b1;
            tick(1);
            mw_done = 1'b0;
        end
        checkOutput({name, ".cmd_ok"}, int'(cmd_ok), int'(expOk));
        tick(1);
        checkOutput({name, ".cmd_ok_pulse"}, int'(cmd_ok), 0);
    endtask

    task automatic randomAudio(input string name, input int n);
        int expL[$];
        int expR[$];
        for (int k = 0; k < n + 2; k++) begin
            if (k >= 2) begin
                checkOutput({name, ".audio_l"}, int'($signed(audio_l)), expL.pop_front());
                checkOutput({name, ".audio_r"}, int'($signed(audio_r)), expR.pop_front());
            end
            dma_l = 8'($urandom_range(0, 255));
            dma_r = 8'($urandom_range(0, 255));
            psg   = 8'($urandom_range(0, 255));
            expL.push_back(expAudio(int'(dma_l), int'(psg), mLeft));
            expR.push_back(expAudio(int'(dma_r), int'(psg), mRight));
            tick(1);
        end
    endtask

    task automatic resetDut(input string name);
        mw_strobe = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
        dma_l = 8'd200; dma_r = 8'd100; psg = 8'd128;
        reset = 1'b1;
        tick(3);
        mMaster = 40; mLeft = 20; mRight = 20; mBass = 6; mTreble = 6; mMix = 1;
        checkOutput({name, ".rst_audio_l"}, int'(audio_l), 0);
        checkOutput({name, ".rst_audio_r"}, int'(audio_r), 0);
        checkOutput({name, ".rst_bass"}, int'(bass), 6);
        checkOutput({name, ".rst_treble"}, int'(treble), 6);
        checkOutput({name, ".rst_cmd_ok"}, int'(cmd_ok), 0);
        reset = 1'b0;
        tick(1);
        checkOutput({name, ".resume1_audio_l"}, int'($signed(audio_l)), 0);
        tick(1);
        checkOutput({name, ".resume2_audio_l"}, int'($signed(audio_l)), 71);
        checkOutput({name, ".resume2_audio_r"}, int'($signed(audio_r)), expAudio(100, 128, 20));
    endtask

    initial begin
        logic [11:0] full;
        bit          ok;
        int          n;

        vecs[0]  = '{12'b0_10_001_001111, 11, 1'b0, 1'b1, 12, 6};
        vecs[1]  = '{12'b0_10_010_000011, 11, 1'b1, 1'b1, 12, 3};
        vecs[2]  = '{12'b0_01_001_000101, 11, 1'b0, 1'b0, 12, 3};
        vecs[3]  = '{12'b00_1000100010,   10, 1'b0, 1'b0, 12, 3};
        vecs[4]  = '{12'b0_10_001_000010, 12, 1'b0, 1'b0, 12, 3};
        vecs[5]  = '{12'b0_10_110_000001, 11, 1'b0, 1'b0, 12, 3};
        vecs[6]  = '{12'b0_10_011_011101, 11, 1'b0, 1'b1, 12, 3};
        vecs[7]  = '{12'b0_10_101_111111, 11, 1'b1, 1'b1, 12, 3};
        vecs[8]  = '{12'b0_10_100_000101, 11, 1'b0, 1'b1, 12, 3};
        vecs[9]  = '{12'b0_10_000_000000, 11, 1'b0, 1'b1, 12, 3};
        vecs[10] = '{12'b0_10_111_000000, 11, 1'b1, 1'b0, 12, 3};
        vecs[11] = '{12'b0_10_001_000000, 11, 1'b0, 1'b1, 0, 3};

        resetDut("init");
        randomAudio("defaults", 6);

        for (int v = 0; v < 12; v++) begin
            ok = modelFrame(vecs[v].bits, vecs[v].n);
            applyStimulus($sformatf("vec%0d", v), vecs[v].bits, vecs[v].n,
                          vecs[v].doneWithLast, vecs[v].expOk);
            checkOutput($sformatf("vec%0d.bass", v), int'(bass), vecs[v].expBass);
            checkOutput($sformatf("vec%0d.treble", v), int'(treble), vecs[v].expTreble);
            randomAudio($sformatf("vec%0d", v), 6);
        end

        for (int r = 0; r < 20; r++) begin
            full = {1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
                    3'($urandom_range(0, 7)), 6'($urandom_range(0, 63))};
            case ($urandom_range(0, 4))
                0:       begin n = 10; full = full >> 1; end
                1:       n = 12;
                default: n = 11;
            endcase
            ok = modelFrame(full, n);
            applyStimulus($sformatf("rnd%0d", r), full, n, 1'($urandom_range(0, 1)), ok);
            checkOutput($sformatf("rnd%0d.bass", r), int'(bass), mBass);
            checkOutput($sformatf("rnd%0d.treble", r), int'(treble), mTreble);
            randomAudio($sformatf("rnd%0d", r), 4);
        end

        ok = modelFrame(12'b0_10_011_101000, 11);
        applyStimulus("master40", 12'b0_10_011_101000, 11, 1'b0, 1'b1);
        ok = modelFrame(12'b0_10_101_010100, 11);
        applyStimulus("left20", 12'b0_10_101_010100, 11, 1'b0, 1'b1);
        ok = modelFrame(12'b0_10_000_000000, 11);
        applyStimulus("mix00", 12'b0_10_000_000000, 11, 1'b0, 1'b1);
        dma_l = 8'd128; psg = 8'd192;
        tick(3);
        checkOutput("mix00.audio_l", int'($signed(audio_l)), 15);
        ok = modelFrame(12'b0_10_000_000001, 11);
        applyStimulus("mix01", 12'b0_10_000_000001, 11, 1'b0, 1'b1);
        dma_l = 8'd128; psg = 8'd192;
        tick(3);
        checkOutput("mix01.audio_l", int'($signed(audio_l)), 63);
        ok = modelFrame(12'b0_10_000_000010, 11);
        applyStimulus("mix10", 12'b0_10_000_000010, 11, 1'b0, 1'b1);
        dma_l = 8'd128; psg = 8'd192;
        tick(3);
        checkOutput("mix10.audio_l", int'($signed(audio_l)), 0);

        ok = modelFrame(12'b0_10_011_000000, 11);
        applyStimulus("master0", 12'b0_10_011_000000, 11, 1'b1, 1'b1);
        ok = modelFrame(12'b0_10_101_000000, 11);
        applyStimulus("left0", 12'b0_10_101_000000, 11, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            dma_l = 8'($urandom_range(0, 255));
            psg   = 8'($urandom_range(0, 255));
            tick(2);
            checkOutput($sformatf("mute%0d.audio_l", k), int'($signed(audio_l)), 0);
        end

        sendBits(12'b0_10_001_000001 >> 6, 5, 1'b0);
        resetDut("midxfer");
        applyStimulus("midxfer.tail", 12'b0000_0000_0001, 6, 1'b0, 1'b0);
        checkOutput("midxfer.bass", int'(bass), 6);
        applyStimulus("midxfer.done_only", 12'd0, 0, 1'b0, 1'b0);
        checkOutput("midxfer.bass2", int'(bass), 6);
        randomAudio("after_reset", 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lmc1992_mixer.md
LMC1992_MIXER -- requirements
Module: lmc1992_mixer

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- mw_strobe  in  1  one-cycle pulse per microwire bit slot (every 8 clk).
- mw_clk  in  1  mask bit for the current slot; the slot carries a valid bit when 1.
- mw_data  in  1  microwire data bit, MSB first.
- mw_done  in  1  one-cycle end-of-transfer pulse.
- dma_l, dma_r  in  8  DMA sound samples, offset binary (128 = zero).
- psg  in  8  PSG sample, offset binary.
- audio_l, audio_r  out  10  mixed, attenuated samples, two's complement.
- bass, treble  out  4  tone codes for an external filter.
- cmd_ok  out  1  one-cycle pulse when a command is accepted.
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL, on each cycle with mw_strobe=1 and mw_clk=1, shift mw_data into an 11-bit shift register (LSB in) and increment a bit counter that saturates at 12.
REQ-004 SHALL, on mw_done=1, accept the word only if counter==11 and word[10:9]==2'b10; otherwise discard it; the counter clears to 0 in either case.
REQ-005 SHALL treat a strobe and mw_done in the same cycle as shift-then-evaluate, with the shifted bit included.
REQ-006 SHALL decode an accepted word as cmd=word[8:6] and val=word[5:0]:
- 000 mix=val[1:0]
- 001 bass=min(val,12)
- 010 treble=min(val,12)
- 011 master=min(val,40)
- 100 right=min(val,20)
- 101 left=min(val,20)
- 110 and 111: ignored, no cmd_ok.
REQ-007 SHALL pulse cmd_ok exactly one cycle, in the cycle after the accepting mw_done.
REQ-008 SHALL make register updates visible on the outputs no earlier than the cycle after acceptance.
REQ-009 SHALL convert inputs to signed values: s = in - 128, range -128..127.
REQ-010 SHALL mix per channel by mix code (10-bit signed sum, no saturation needed):
- 00: dma + (psg >>> 2)
- 01: dma + psg
- 10 and 11: dma only.
REQ-011 SHALL compute the attenuation index per channel as (40 - master) + (20 - left or right), in 2 dB units, clamped to 40.
REQ-012 SHALL map the index through a 41-entry ROM, gain[i] = round-half-up(255 * 10^(-i/10)):
- gain[0]=255, gain[3]=128, gain[10]=26, gain[40]=0.
REQ-013 SHALL compute audio = (sum * gain) >>> 8, arithmetic shift, truncated toward negative infinity, and the result SHALL fit 10 bits signed.
REQ-014 SHALL pipeline the datapath in two stages:
- stage 1 registers the sum and gain;
- stage 2 registers the product.
Input-to-output latency is exactly 2 clk, computed every cycle.
REQ-015 SHALL drive bass and treble directly from their registers.

Reset
REQ-016 SHALL, while reset=1, set:
- master=40, left=20, right=20, bass=6, treble=6, mix=01;
- shift register=0, counter=0;
- cmd_ok=0, audio_l=audio_r=0 and both pipeline stages=0.
REQ-017 SHALL make reset asserted mid-transfer discard all partial bits; a later mw_done with no new bits is rejected.
REQ-018 SHALL resume valid audio output 2 cycles after reset deasserts.

Verification
REQ-019 Defaults: after reset, dma_l=200, psg=128 -> audio_l=71 after 2 clk (72*255>>8=71).
REQ-020 Master write: 11 bits 10_011_011101 (master=29, index 11) then mw_done -> cmd_ok one cycle later; later audio uses gain[11].
REQ-021 Bad frames rejected, no cmd_ok, registers unchanged:
- 10 bits then mw_done;
- 12 bits then mw_done;
- address 01.
REQ-022 Clamping: left=63 is stored as 20; bass=15 is stored as 12; master=0 with left=0 gives index 40 -> audio_l=0 for any input.
REQ-023 Mix modes: dma_l=128, psg=192 gives audio_l:
- mix=00 -> 15
- mix=01 -> 63
- mix=10 -> 0
REQ-024 Reset at bit 5 of a transfer, then 6 more bits and mw_done -> rejected (counter==6).
